// File: rtl/vga_timing_pkg.sv
// Mode constants and raster-region helper for the VGA timing generator.
// Default mode is 1024x768@60; a 640x480@60 set is provided as an alternative.
package vga_timing_pkg;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam int XGA_H_TOTAL  = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int XGA_V_TOTAL  = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_H_TOTAL  = VGA640_H_ACTIVE + VGA640_H_FP + VGA640_H_SYNC + VGA640_H_BP;
  localparam int VGA640_V_TOTAL  = VGA640_V_ACTIVE + VGA640_V_FP + VGA640_V_SYNC + VGA640_V_BP;

  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT  = 2'd1,
    REG_SYNC   = 2'd2,
    REG_BACK   = 2'd3
  } region_e;

  // Regions are contiguous, so each state only watches the count that opens the next one.
  function automatic region_e next_region(input region_e    cur,
                                          input logic [10:0] pos,
                                          input logic [10:0] act_end,
                                          input logic [10:0] fp_end,
                                          input logic [10:0] sync_end);
    region_e nxt;
    nxt = cur;
    case (cur)
      REG_ACTIVE: if (pos == act_end)  nxt = REG_FRONT;
      REG_FRONT:  if (pos == fp_end)   nxt = REG_SYNC;
      REG_SYNC:   if (pos == sync_end) nxt = REG_BACK;
      REG_BACK:   if (pos == 11'd0)    nxt = REG_ACTIVE;
      default:                         nxt = REG_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that lines sync/blank up with the delayed pixel path.
// Reset fills every stage with RST_VAL.
module vga_sync_delay #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counts, syncs, blank and line/frame strobes, all registered.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/blank by PIX_LAT enabled cycles.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = vga_timing_pkg::XGA_H_ACTIVE,
  parameter int H_FP      = vga_timing_pkg::XGA_H_FP,
  parameter int H_SYNC    = vga_timing_pkg::XGA_H_SYNC,
  parameter int H_BP      = vga_timing_pkg::XGA_H_BP,
  parameter int V_ACTIVE  = vga_timing_pkg::XGA_V_ACTIVE,
  parameter int V_FP      = vga_timing_pkg::XGA_V_FP,
  parameter int V_SYNC    = vga_timing_pkg::XGA_V_SYNC,
  parameter int V_BP      = vga_timing_pkg::XGA_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIX_LAT   = 2
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic        en,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIX_LAT < 0) begin : g_bad_mode
    $error("vga_timing_gen: H_TOTAL must be <= 2048, V_TOTAL <= 1024, PIX_LAT >= 0");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_FP_END   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_FP_END   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  region_e     h_state_q, h_state_d;
  region_e     v_state_q, v_state_d;
  logic        hsync_q, vsync_q, blank_q, line_start_q, frame_start_q;

  // Everything is decoded from the next counts so all outputs land on the same pixel.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
    h_state_d = next_region(h_state_q, hcount_d, H_ACT_END, H_FP_END, H_SYNC_END);
    v_state_d = next_region(v_state_q, {1'b0, vcount_d}, V_ACT_END, V_FP_END, V_SYNC_END);
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      h_state_q     <= REG_ACTIVE;
      v_state_q     <= REG_ACTIVE;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else if (en) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      hsync_q       <= (h_state_d == REG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= (v_state_d == REG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      blank_q       <= (h_state_d != REG_ACTIVE) || (v_state_d != REG_ACTIVE);
      line_start_q  <= (hcount_d == 11'd0);
      frame_start_q <= (hcount_d == 11'd0) && (vcount_d == 10'd0);
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [2:0] sync_dly;

  vga_sync_delay #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT),
    .RST_VAL ({1'b1, ~VSYNC_POL, ~HSYNC_POL})
  ) u_sync_delay (
    .clk_i (pixel_clk),
    .rst_i (reset),
    .en_i  (en),
    .d_i   ({blank_q, vsync_q, hsync_q}),
    .q_o   (sync_dly)
  );

  assign {blank, vsync, hsync} = sync_dly;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign blank = blank_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-size XGA instance for line-level checks
// and a tiny-mode instance so frame-level behaviour fits in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        ls;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic en;

  logic [10:0] hcount_x, hcount_s;
  logic [9:0]  vcount_x, vcount_s;
  logic        hsync_x, vsync_x, blank_x, ls_x, fs_x;
  logic        hsync_s, vsync_s, blank_s, ls_s, fs_s;

  int checks = 0;
  int errors = 0;

  // Instance 0: XGA timing; instance 1: 16/2/3/3 x 10/1/2/2 (24 x 15).
  int ha[2]   = '{1024, 16};
  int hf[2]   = '{24, 2};
  int hsw[2]  = '{136, 3};
  int htot[2] = '{1344, 24};
  int va[2]   = '{768, 10};
  int vf[2]   = '{3, 1};
  int vsw[2]  = '{6, 2};
  int vtot[2] = '{806, 15};

  int         mh[2];
  int         mv[2];
  logic [2:0] cur[2];
  logic [2:0] pipe[2][2];

  exp_t sb_x[$];
  exp_t sb_s[$];

  always #5 clk = ~clk;

  vga_timing_gen #(.PIX_LAT(2)) dut_x (
    .pixel_clk   (clk),
    .reset       (reset),
    .en          (en),
    .hcount      (hcount_x),
    .vcount      (vcount_x),
    .hsync       (hsync_x),
    .vsync       (vsync_x),
    .blank       (blank_x),
    .line_start  (ls_x),
    .frame_start (fs_x)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIX_LAT(2)
  ) dut_s (
    .pixel_clk   (clk),
    .reset       (reset),
    .en          (en),
    .hcount      (hcount_s),
    .vcount      (vcount_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .blank       (blank_s),
    .line_start  (ls_s),
    .frame_start (fs_s)
  );

  // {blank, vsync, hsync} straight from the raster position, negative sync polarity.
  function automatic logic [2:0] und_of(int i, int h, int v);
    logic hs_a, vs_a, bl;
    hs_a = (h >= ha[i] + hf[i]) && (h < ha[i] + hf[i] + hsw[i]);
    vs_a = (v >= va[i] + vf[i]) && (v < va[i] + vf[i] + vsw[i]);
    bl   = (h >= ha[i]) || (v >= va[i]);
    return {bl, ~vs_a, ~hs_a};
  endfunction

  task automatic model_reset(int i);
    mh[i] = 0;
    mv[i] = 0;
    pipe[i][0] = 3'b111;
    pipe[i][1] = 3'b111;
    cur[i] = und_of(i, 0, 0);
  endtask

  task automatic model_step(int i);
    pipe[i][1] = pipe[i][0];
    pipe[i][0] = cur[i];
    if (mh[i] == htot[i] - 1) begin
      mh[i] = 0;
      mv[i] = (mv[i] == vtot[i] - 1) ? 0 : mv[i] + 1;
    end else begin
      mh[i] = mh[i] + 1;
    end
    cur[i] = und_of(i, mh[i], mv[i]);
  endtask

  function automatic exp_t make_exp(int i);
    exp_t e;
    logic [2:0] o;
    o = (LAT == 0) ? cur[i] : pipe[i][1];
    e.h  = 11'(mh[i]);
    e.v  = 10'(mv[i]);
    e.bl = o[2];
    e.vs = o[1];
    e.hs = o[0];
    e.ls = (mh[i] == 0);
    e.fs = (mh[i] == 0) && (mv[i] == 0);
    return e;
  endfunction

  // One clock: drive en, advance the model, queue the expectation, wait out the edge.
  task automatic drive(input logic en_v);
    en = en_v;
    for (int i = 0; i < 2; i++) begin
      if (reset) model_reset(i);
      else if (en_v) model_step(i);
    end
    sb_x.push_back(make_exp(0));
    sb_s.push_back(make_exp(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (sb_x.size() > 0) begin
      e = sb_x.pop_front();
      a = '{hcount_x, vcount_x, hsync_x, vsync_x, blank_x, ls_x, fs_x};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_xga t=%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                 $time, a.h, a.v, a.hs, a.vs, a.bl, a.ls, a.fs, e.h, e.v, e.hs, e.vs, e.bl, e.ls, e.fs);
      end
    end
    if (sb_s.size() > 0) begin
      e = sb_s.pop_front();
      a = '{hcount_s, vcount_s, hsync_s, vsync_s, blank_s, ls_s, fs_s};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL sb_small t=%0t: got h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b, expected h=%0d v=%0d hs=%b vs=%b bl=%b ls=%b fs=%b",
                 $time, a.h, a.v, a.hs, a.vs, a.bl, a.ls, a.fs, e.h, e.v, e.hs, e.vs, e.bl, e.ls, e.fs);
      end
    end
  end

  task automatic test_reset();
    logic bl_rst;
    bl_rst = (LAT > 0);
    reset = 1'b1;
    repeat (5) drive(1'b1);
    reset = 1'b0;
    #1;
    checks++;
    if (hcount_x !== 11'd0 || vcount_x !== 10'd0) begin
      errors++;
      $display("FAIL reset_counts: got h=%0d v=%0d, expected 0 0", hcount_x, vcount_x);
    end
    checks++;
    if (fs_x !== 1'b1 || ls_x !== 1'b1) begin
      errors++;
      $display("FAIL reset_strobes: got ls=%b fs=%b, expected 1 1", ls_x, fs_x);
    end
    checks++;
    if (hsync_x !== 1'b1 || vsync_x !== 1'b1 || blank_x !== bl_rst) begin
      errors++;
      $display("FAIL reset_sync: got hs=%b vs=%b bl=%b, expected 1 1 %b", hsync_x, vsync_x, blank_x, bl_rst);
    end
  endtask

  task automatic test_line();
    int low = 0, nls = 0, fall_h = -1, rise_h = -1;
    logic phs, pbl;
    phs = hsync_x;
    pbl = blank_x;
    for (int c = 0; c < 1344; c++) begin
      drive(1'b1);
      if (!hsync_x) low++;
      if (ls_x) nls++;
      if (phs && !hsync_x && fall_h < 0) fall_h = int'(hcount_x);
      if (!pbl && blank_x && rise_h < 0) rise_h = int'(hcount_x);
      phs = hsync_x;
      pbl = blank_x;
    end
    checks++;
    if (low != 136) begin errors++; $display("FAIL hsync_width: got %0d, expected 136", low); end
    checks++;
    if (nls != 1) begin errors++; $display("FAIL line_start_count: got %0d, expected 1", nls); end
    checks++;
    if (fall_h != 1048 + LAT) begin errors++; $display("FAIL hsync_fall_pos: got %0d, expected %0d", fall_h, 1048 + LAT); end
    checks++;
    if (rise_h != 1024 + LAT) begin errors++; $display("FAIL blank_rise_pos: got %0d, expected %0d", rise_h, 1024 + LAT); end
    checks++;
    if (hcount_x !== 11'd0 || vcount_x !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: got h=%0d v=%0d, expected 0 1", hcount_x, vcount_x);
    end
  endtask

  task automatic test_frame();
    int vlow = 0, nfs = 0, nbl = 0, bad_vedge = 0, fs_run = 0, vfall_v = -1;
    logic pvs, pfs;
    pvs = vsync_s;
    pfs = fs_s;
    for (int c = 0; c < 2 * 360; c++) begin
      drive(1'b1);
      if (!vsync_s) vlow++;
      if (fs_s) nfs++;
      if (blank_s) nbl++;
      if (fs_s && pfs) fs_run++;
      if (vsync_s !== pvs && hcount_s !== 11'(LAT)) bad_vedge++;
      if (pvs && !vsync_s && vfall_v < 0) vfall_v = int'(vcount_s);
      pvs = vsync_s;
      pfs = fs_s;
    end
    checks++;
    if (vlow != 96) begin errors++; $display("FAIL vsync_low_cycles: got %0d, expected 96", vlow); end
    checks++;
    if (nfs != 2) begin errors++; $display("FAIL frame_start_count: got %0d, expected 2", nfs); end
    checks++;
    if (fs_run != 0) begin errors++; $display("FAIL frame_start_width: got %0d long pulses, expected 0", fs_run); end
    checks++;
    if (nbl != 400) begin errors++; $display("FAIL blank_cycles: got %0d, expected 400", nbl); end
    checks++;
    if (bad_vedge != 0) begin errors++; $display("FAIL vsync_line_edge: got %0d off-boundary edges, expected 0", bad_vedge); end
    checks++;
    if (vfall_v != 11) begin errors++; $display("FAIL vsync_fall_line: got %0d, expected 11", vfall_v); end
  endtask

  task automatic test_en_toggle();
    int sh, sv, rises = 0, highs = 0;
    logic pfs;
    sh = mh[1];
    sv = mv[1];
    pfs = fs_s;
    for (int c = 0; c < 2 * 360; c++) begin
      drive((c % 2) == 0);
      if (fs_s && !pfs) rises++;
      if (fs_s) highs++;
      pfs = fs_s;
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL en_frame_rises: got %0d, expected 1", rises); end
    checks++;
    if (highs != 2) begin errors++; $display("FAIL en_frame_hold: got %0d, expected 2", highs); end
    checks++;
    if (int'(hcount_s) != sh || int'(vcount_s) != sv) begin
      errors++;
      $display("FAIL en_half_rate: got h=%0d v=%0d, expected %0d %0d", hcount_s, vcount_s, sh, sv);
    end
  endtask

  task automatic test_async_reset();
    int n = 0, low = 0;
    logic bl_rst;
    bl_rst = (LAT > 0);
    while (!(mh[1] == 7 && mv[1] == 5) && n < 400) begin
      drive(1'b1);
      n++;
    end
    checks++;
    if (hcount_s !== 11'd7 || vcount_s !== 10'd5) begin
      errors++;
      $display("FAIL midframe_reach: got h=%0d v=%0d, expected 7 5", hcount_s, vcount_s);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (hcount_s !== 11'd0 || vcount_s !== 10'd0 || ls_s !== 1'b1 || fs_s !== 1'b1) begin
      errors++;
      $display("FAIL async_counts: got h=%0d v=%0d ls=%b fs=%b, expected 0 0 1 1", hcount_s, vcount_s, ls_s, fs_s);
    end
    checks++;
    if (hsync_s !== 1'b1 || vsync_s !== 1'b1 || blank_s !== bl_rst || hcount_x !== 11'd0) begin
      errors++;
      $display("FAIL async_sync: got hs=%b vs=%b bl=%b hx=%0d, expected 1 1 %b 0", hsync_s, vsync_s, blank_s, hcount_x, bl_rst);
    end
    drive(1'b1);
    drive(1'b1);
    reset = 1'b0;
    for (int c = 0; c < 24; c++) begin
      drive(1'b1);
      if (!hsync_s) low++;
    end
    checks++;
    if (low != 3) begin errors++; $display("FAIL restart_hsync_width: got %0d, expected 3", low); end
    repeat (360) drive(1'b1);
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    test_reset();
    test_line();
    test_frame();
    test_en_toggle();
    test_async_reset();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete within 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
